pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 4: EXE-occupancy cycles of a multiply.
REQ-002 Parameter DIV_CYCLES, default 32: EXE-occupancy cycles of a divide.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 id_rs  in  5  source register 1 of the instruction in ID.
REQ-006 id_rt  in  5  source register 2 of the instruction in ID.
REQ-007 id_uses_rs  in  1  ID instruction reads id_rs.
REQ-008 id_uses_rt  in  1  ID instruction reads id_rt.
REQ-009 id_md_op  in  2  ID multiply/divide issue: 00 none, 01 mult, 10 div, 11 treated as none.
REQ-010 id_reads_hilo  in  1  ID instruction reads HI/LO (mfhi/mflo).
REQ-011 exe_num_write  in  5  destination register of the instruction in EXE.
REQ-012 exe_reg_write  in  1  EXE instruction writes the register file.
REQ-013 exe_is_load  in  1  EXE instruction is a load.
REQ-014 exe_branch_taken  in  1  branch/jump in EXE resolved taken this cycle.
REQ-015 pc_write  out  1  PC update enable.
REQ-016 if_id_write  out  1  IF/ID register load enable.
REQ-017 if_id_flush  out  1  clear IF/ID to a bubble at next edge.
REQ-018 id_exe_flush  out  1  drives the ID/EXE register's ID_EXE_flush input; 1 inserts a bubble at next edge.
REQ-019 md_busy  out  1  multiply/divide unit occupied.
REQ-020 md_done  out  1  one-cycle pulse on the last busy cycle.
REQ-021 stall_cnt  out  16  count of stall cycles, saturating.

Function
REQ-022 State: 2-state FSM {RUN, MD_BUSY} plus 6-bit down-counter md_cnt; outputs are Mealy (combinational from state and inputs), state/counters registered.
REQ-023 load_use = exe_is_load & exe_reg_write & (exe_num_write != 0) & ((id_uses_rs & id_rs == exe_num_write) | (id_uses_rt & id_rt == exe_num_write)).
REQ-024 md_hazard = md_busy & (id_reads_hilo | id_md_op is 01 or 10).
REQ-025 stall = load_use | md_hazard, forced 0 when exe_branch_taken = 1.
REQ-026 Priority per cycle: exe_branch_taken > stall > normal flow.
REQ-027 Taken branch: pc_write=1, if_id_write=1, if_id_flush=1, id_exe_flush=1; FSM and md_cnt unaffected.
REQ-028 Stall: pc_write=0, if_id_write=0, if_id_flush=0, id_exe_flush=1; exactly one bubble per stall cycle, ID instruction held.
REQ-029 Normal flow: pc_write=1, if_id_write=1, if_id_flush=0, id_exe_flush=0.
REQ-030 Issue: in RUN, id_md_op 01/10 with no branch and no load_use -> next state MD_BUSY, md_cnt <= MULT_CYCLES-1 or DIV_CYCLES-1.
REQ-031 MD_BUSY: md_busy=1; md_cnt decrements each cycle; at md_cnt==0 md_done=1 and next state RUN; md_hazard clears the same cycle md_busy falls.
REQ-032 md_op issued while busy is stalled and issues only after return to RUN (no back-to-back overlap).
REQ-033 A taken branch during MD_BUSY does not abort the multiply/divide; counting continues.
REQ-034 stall_cnt increments by 1 on every cycle stall=1, holds at 16'hFFFF.
REQ-035 Register 0 never causes a load-use stall.

Reset
REQ-036 While reset=1 (sampled at edge): state=RUN, md_cnt=0, stall_cnt=0, md_busy=0, md_done=0.
REQ-037 While reset=1 outputs: pc_write=0, if_id_write=0, if_id_flush=1, id_exe_flush=1.
REQ-038 Reset asserted mid-MD_BUSY aborts the operation; no md_done pulse follows.

Verification
REQ-039 lw $5 in EXE (exe_is_load=1, exe_num_write=5), ID add uses rs=5 -> one cycle pc_write=0, id_exe_flush=1, stall_cnt 0->1.
REQ-040 Same, but exe_num_write=0 or id_uses_rs=0 -> no stall, id_exe_flush=0.
REQ-041 load_use and exe_branch_taken same cycle -> if_id_flush=1, id_exe_flush=1, pc_write=1, stall_cnt unchanged.
REQ-042 Issue div (id_md_op=10), then mflo in ID -> md_busy=1 for 32 cycles, id_exe_flush=1 each cycle, md_done on 32nd, mflo proceeds next cycle; stall_cnt=32.
REQ-043 mult issued, reset asserted on 2nd busy cycle -> next cycle md_busy=0, stall_cnt=0, no md_done.
REQ-044 Force 70000 consecutive stall cycles -> stall_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath and the hazard controller.
// The master is the datapath: it reports the ID/EXE stage facts and consumes
// the pipeline-control and multiply/divide status outputs.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [1:0]  id_md_op;
    logic        id_reads_hilo;
    logic [4:0]  exe_num_write;
    logic        exe_reg_write;
    logic        exe_is_load;
    logic        exe_branch_taken;

    logic        pc_write;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_exe_flush;
    logic        md_busy;
    logic        md_done;
    logic [15:0] stall_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_op, id_reads_hilo,
               exe_num_write, exe_reg_write, exe_is_load, exe_branch_taken,
        input  pc_write, if_id_write, if_id_flush, id_exe_flush,
               md_busy, md_done, stall_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_md_op, id_reads_hilo,
               exe_num_write, exe_reg_write, exe_is_load, exe_branch_taken,
        output pc_write, if_id_write, if_id_flush, id_exe_flush,
               md_busy, md_done, stall_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, multiply/divide occupancy
// tracking with HI/LO interlock, taken-branch flush and a saturating stall
// counter. Control outputs are combinational from state and current inputs.
module pipeline_hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic               clock,
    input  logic               reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic {RUN, MD_BUSY} state_t;

    localparam logic [5:0] MULT_INIT = 6'(MULT_CYCLES - 1);
    localparam logic [5:0] DIV_INIT  = 6'(DIV_CYCLES - 1);

    state_t      state;
    logic [5:0]  md_cnt;
    logic [15:0] stall_cnt_q;

    logic md_op_v;
    logic load_use;
    logic busy;
    logic md_hazard;
    logic stall;

    // Hazard detection; busy is masked by reset so an aborted op reads idle at once.
    always_comb begin
        md_op_v   = (hz.id_md_op == 2'b01) || (hz.id_md_op == 2'b10);
        load_use  = hz.exe_is_load && hz.exe_reg_write && (hz.exe_num_write != 5'd0) &&
                    ((hz.id_uses_rs && (hz.id_rs == hz.exe_num_write)) ||
                     (hz.id_uses_rt && (hz.id_rt == hz.exe_num_write)));
        busy      = (state == MD_BUSY) && !reset;
        md_hazard = busy && (hz.id_reads_hilo || md_op_v);
        stall     = (load_use || md_hazard) && !hz.exe_branch_taken;
    end

    // Pipeline control: reset > taken branch > stall > normal flow.
    always_comb begin
        hz.pc_write     = 1'b1;
        hz.if_id_write  = 1'b1;
        hz.if_id_flush  = 1'b0;
        hz.id_exe_flush = 1'b0;
        if (reset) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.if_id_flush  = 1'b1;
            hz.id_exe_flush = 1'b1;
        end else if (hz.exe_branch_taken) begin
            hz.if_id_flush  = 1'b1;
            hz.id_exe_flush = 1'b1;
        end else if (stall) begin
            hz.pc_write     = 1'b0;
            hz.if_id_write  = 1'b0;
            hz.id_exe_flush = 1'b1;
        end
        hz.md_busy   = busy;
        hz.md_done   = busy && (md_cnt == 6'd0);
        hz.stall_cnt = stall_cnt_q;
    end

    // FSM, occupancy counter and saturating stall counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            md_cnt      <= 6'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (stall && (stall_cnt_q != 16'hFFFF))
                stall_cnt_q <= stall_cnt_q + 16'd1;
            case (state)
                RUN: begin
                    // A flushed or interlocked instruction never reaches EXE, so it cannot issue.
                    if (md_op_v && !hz.exe_branch_taken && !load_use) begin
                        state  <= MD_BUSY;
                        md_cnt <= (hz.id_md_op == 2'b01) ? MULT_INIT : DIV_INIT;
                    end
                end
                MD_BUSY: begin
                    // Branches do not abort an op in flight; only reset does.
                    if (md_cnt == 6'd0)
                        state <= RUN;
                    else
                        md_cnt <= md_cnt - 6'd1;
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. The driver applies one vector per
// cycle and queues the hand-derived expected outputs; a monitor on the falling
// edge pops and compares whatever the DUT presents that cycle.
module tb_pipeline_hazard_ctrl;
    localparam int K_NRM = 0;
    localparam int K_STL = 1;
    localparam int K_BRN = 2;
    localparam int K_RST = 3;

    typedef struct {
        string       name;
        logic [21:0] val;   // {pcw, ifw, iff, idf, busy, done, stall_cnt}
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (bus)
    );

    always #5 clock = ~clock;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] sc_m    = 16'd0;

    // Monitor: outputs are valid every cycle; compare on the falling edge.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t        e;
            logic [21:0] act;
            e   = q.pop_front();
            act = {bus.pc_write, bus.if_id_write, bus.if_id_flush, bus.id_exe_flush,
                   bus.md_busy, bus.md_done, bus.stall_cnt};
            n_tests++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got pcw/ifw/iff/idf/busy/done=%b sc=%h, want %b sc=%h",
                         e.name, act[21:16], act[15:0], e.val[21:16], e.val[15:0]);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", q.size());
        $fatal(1);
    end

    task automatic idle();
        bus.id_rs            = 5'd0;
        bus.id_rt            = 5'd0;
        bus.id_uses_rs       = 1'b0;
        bus.id_uses_rt       = 1'b0;
        bus.id_md_op         = 2'b00;
        bus.id_reads_hilo    = 1'b0;
        bus.exe_num_write    = 5'd0;
        bus.exe_reg_write    = 1'b0;
        bus.exe_is_load      = 1'b0;
        bus.exe_branch_taken = 1'b0;
    endtask

    task automatic lw_use(input logic [4:0] r);
        bus.exe_is_load   = 1'b1;
        bus.exe_reg_write = 1'b1;
        bus.exe_num_write = r;
        bus.id_rs         = r;
        bus.id_uses_rs    = 1'b1;
    endtask

    // One cycle: optionally queue the expected outputs, advance the counter model, step.
    task automatic cyc(input string nm, input int kind, input logic busy, input logic done,
                       input bit push = 1'b1);
        exp_t e;
        logic [3:0] ctl;
        case (kind)
            K_STL:   ctl = 4'b0001;
            K_BRN:   ctl = 4'b1111;
            K_RST:   ctl = 4'b0011;
            default: ctl = 4'b1100;
        endcase
        e.name = nm;
        e.val  = {ctl, busy, done, sc_m};
        if (push) q.push_back(e);
        if (kind == K_RST)                       sc_m = 16'd0;
        else if (kind == K_STL && sc_m != 16'hFFFF) sc_m = sc_m + 16'd1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clock);
        #1;
        cyc("reset", K_RST, 0, 0);
        reset = 1'b0;
        cyc("idle", K_NRM, 0, 0);

        // Load-use interlocks
        lw_use(5'd5);                              cyc("lu_rs", K_STL, 0, 0);
        idle();                                    cyc("lu_after", K_NRM, 0, 0);
        lw_use(5'd0);                              cyc("lu_r0", K_NRM, 0, 0);
        lw_use(5'd5); bus.id_uses_rs = 1'b0;       cyc("lu_no_rs", K_NRM, 0, 0);
        idle(); bus.exe_is_load = 1'b1; bus.exe_reg_write = 1'b1; bus.exe_num_write = 5'd7;
        bus.id_rt = 5'd7; bus.id_uses_rt = 1'b1;   cyc("lu_rt", K_STL, 0, 0);
        bus.exe_reg_write = 1'b0;                  cyc("lu_no_wr", K_NRM, 0, 0);
        idle(); lw_use(5'd9); bus.exe_branch_taken = 1'b1;
                                                   cyc("lu_branch", K_BRN, 0, 0);
        idle();                                    cyc("post_branch", K_NRM, 0, 0);
        bus.id_md_op = 2'b11;                      cyc("md_op_11", K_NRM, 0, 0);
        idle();                                    cyc("md_11_noissue", K_NRM, 0, 0);

        // Issue suppressed by load-use or taken branch
        lw_use(5'd3); bus.id_md_op = 2'b01;        cyc("issue_lu", K_STL, 0, 0);
        idle();                                    cyc("issue_lu_none", K_NRM, 0, 0);
        bus.id_md_op = 2'b01; bus.exe_branch_taken = 1'b1;
                                                   cyc("issue_br", K_BRN, 0, 0);
        idle();                                    cyc("issue_br_none", K_NRM, 0, 0);

        // Multiply: branch mid-op, back-to-back md_op held until RUN
        bus.id_md_op = 2'b01;                      cyc("mult_issue", K_NRM, 0, 0);
        idle();                                    cyc("mult_b1", K_NRM, 1, 0);
        bus.exe_branch_taken = 1'b1;               cyc("mult_b2_br", K_BRN, 1, 0);
        idle(); bus.id_md_op = 2'b01;              cyc("mult_b3_md", K_STL, 1, 0);
                                                   cyc("mult_b4_done", K_STL, 1, 1);
                                                   cyc("mult2_issue", K_NRM, 0, 0);
        idle();                                    cyc("mult2_b1", K_NRM, 1, 0);

        // Reset on the second busy cycle aborts the op
        reset = 1'b1;                              cyc("mult2_rst", K_RST, 0, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++)                cyc($sformatf("post_abort%0d", i), K_NRM, 0, 0);

        // Divide then mflo: 32 interlocked cycles
        bus.id_md_op = 2'b10;                      cyc("div_issue", K_NRM, 0, 0);
        idle(); bus.id_reads_hilo = 1'b1;
        for (int i = 0; i < 32; i++)
            cyc($sformatf("div_mflo%0d", i), K_STL, 1, (i == 31));
                                                   cyc("mflo_go", K_NRM, 0, 0);
        idle();

        // Saturation after 70000 consecutive stalls
        reset = 1'b1;                              cyc("sat_rst", K_RST, 0, 0);
        reset = 1'b0;
        lw_use(5'd12);
        for (int i = 0; i < 70000; i++)
            cyc($sformatf("sat%0d", i), K_STL, 0, 0,
                (i == 0 || i == 1 || i == 65534 || i == 65535 || i == 65536 || i == 69999));
        idle();                                    cyc("sat_hold", K_NRM, 0, 0);

        @(negedge clock);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
